// File: rtl/qcw_ramp_ctrl.sv
// QCW burst sequencer: trigger -> start pulse -> phase ramp -> hold -> holdoff, with latched fault.
// Define QCW_RAMP_WDOG_EN to add a drive-cycle watchdog that faults a stalled burst.
module qcw_ramp_ctrl #(
   parameter int unsigned RAMP_START       = 16,
   parameter int unsigned RAMP_END         = 240,
   parameter int unsigned RAMP_STEP_CYCLES = 4,
   parameter int unsigned HOLDOFF_CLKS     = 100000
`ifdef QCW_RAMP_WDOG_EN
   ,
   parameter int unsigned WDOG_CLKS        = 4096
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger,
   input  logic [15:0] cycle_limit_cfg,
   input  logic        fault_in,
   input  logic        fault_clear,
   input  logic        pll_cycle_finished,
   output logic        pll_start,
   output logic        pll_halt,
   output logic [7:0]  pll_phase_shift,
   output logic [15:0] pll_cycle_limit,
   output logic        busy,
   output logic        burst_done,
   output logic        fault
);

   localparam logic [7:0]  PH_START = 8'(RAMP_START);
   localparam logic [7:0]  PH_END   = 8'(RAMP_END);
   localparam logic [15:0] STEP_N   = 16'(RAMP_STEP_CYCLES);
   localparam logic [31:0] HOLD_N   = 32'(HOLDOFF_CLKS);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_RAMP, S_HOLD, S_COOLDOWN, S_FAULT
   } state_t;

   state_t      state_q, state_d;
   logic        trig_q, trig_d, trig_prev_q, trig_prev_d;
   logic [15:0] cyc_q, cyc_d, step_q, step_d, limit_q, limit_d;
   logic [7:0]  phase_q, phase_d;
   logic [31:0] hold_q, hold_d;
   logic        start_q, start_d, halt_q, halt_d, busy_q, busy_d;
   logic        done_q, done_d, fault_q, fault_d;
   logic        trig_edge, fault_now;
`ifdef QCW_RAMP_WDOG_EN
   localparam logic [15:0] WDOG_N = 16'(WDOG_CLKS);
   logic [15:0] wdog_q, wdog_d;
   logic        wdog_trip;
`endif

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      step_d      = step_q;
      limit_d     = limit_q;
      phase_d     = phase_q;
      hold_d      = hold_q;
      done_d      = 1'b0;
      trig_d      = trigger;
      trig_prev_d = trig_q;
      trig_edge   = trig_q & ~trig_prev_q;
      fault_now   = fault_in;
`ifdef QCW_RAMP_WDOG_EN
      wdog_d      = wdog_q;
      wdog_trip   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (trig_edge && (cycle_limit_cfg != 16'd0)) begin
               state_d = S_ARM;
               limit_d = cycle_limit_cfg;
               phase_d = PH_START;
               cyc_d   = 16'd0;
               step_d  = 16'd0;
`ifdef QCW_RAMP_WDOG_EN
               wdog_d  = 16'd0;
`endif
            end
         end
         S_ARM: begin
            state_d = S_RAMP;
`ifdef QCW_RAMP_WDOG_EN
            wdog_d  = 16'd0;
`endif
         end
         S_RAMP, S_HOLD: begin
`ifdef QCW_RAMP_WDOG_EN
            if (pll_cycle_finished) begin
               wdog_d = 16'd0;
            end else begin
               wdog_d    = wdog_q + 16'd1;
               wdog_trip = (wdog_d == WDOG_N);
            end
`endif
            if (pll_cycle_finished) begin
               cyc_d = cyc_q + 16'd1;
               // Burst end wins over the phase step on the same drive cycle.
               if (cyc_d == limit_q) begin
                  done_d  = 1'b1;
                  hold_d  = HOLD_N;
                  phase_d = 8'd0;
                  state_d = S_COOLDOWN;
               end else if (state_q == S_RAMP) begin
                  step_d = step_q + 16'd1;
                  if (step_d == STEP_N) begin
                     step_d = 16'd0;
                     if (phase_q < PH_END) phase_d = phase_q + 8'd1;
                  end
               end
            end
            if ((state_q == S_RAMP) && (state_d == S_RAMP) && (phase_d >= PH_END))
               state_d = S_HOLD;
         end
         S_COOLDOWN: begin
            if (hold_q <= 32'd1) state_d = S_IDLE;
            else                 hold_d  = hold_q - 32'd1;
         end
         S_FAULT: begin
            if (fault_clear && !fault_in) begin
               state_d = S_COOLDOWN;
               hold_d  = HOLD_N;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef QCW_RAMP_WDOG_EN
      fault_now = fault_in | wdog_trip;
`endif
      if ((state_q != S_FAULT) && fault_now) begin
         state_d = S_FAULT;
         phase_d = 8'd0;
         done_d  = 1'b0;
      end

      start_d = (state_d == S_ARM);
      halt_d  = (state_d == S_FAULT);
      fault_d = (state_d == S_FAULT);
      busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         trig_q      <= 1'b0;
         trig_prev_q <= 1'b0;
         cyc_q       <= 16'd0;
         step_q      <= 16'd0;
         limit_q     <= 16'd0;
         phase_q     <= 8'd0;
         hold_q      <= 32'd0;
         start_q     <= 1'b0;
         halt_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
`ifdef QCW_RAMP_WDOG_EN
         wdog_q      <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_d;
         trig_prev_q <= trig_prev_d;
         cyc_q       <= cyc_d;
         step_q      <= step_d;
         limit_q     <= limit_d;
         phase_q     <= phase_d;
         hold_q      <= hold_d;
         start_q     <= start_d;
         halt_q      <= halt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
`ifdef QCW_RAMP_WDOG_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   assign pll_start       = start_q;
   assign pll_halt        = halt_q;
   assign pll_phase_shift = phase_q;
   assign pll_cycle_limit = limit_q;
   assign busy            = busy_q;
   assign burst_done      = done_q;
   assign fault           = fault_q;

endmodule

// File: tb/tb_qcw_ramp_ctrl.sv
// Randomised bench for qcw_ramp_ctrl against a burst-level reference model.
module tb_qcw_ramp_ctrl;

   localparam int START = 16;
   localparam int END_  = 240;
   localparam int STEP  = 4;
   localparam int HOLD  = 150;
`ifdef QCW_RAMP_WDOG_EN
   localparam int WDOG  = 4096;
`endif
   localparam int STALL = 4200;

   localparam int MI = 0, MA = 1, MR = 2, MH = 3, MC = 4, MF = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trigger = 1'b0;
   logic [15:0] cycle_limit_cfg = 16'd0;
   logic        fault_in = 1'b0;
   logic        fault_clear = 1'b0;
   logic        pll_cycle_finished = 1'b0;
   logic        pll_start, pll_halt, busy, burst_done, fault;
   logic [7:0]  pll_phase_shift;
   logic [15:0] pll_cycle_limit;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int   mode = MI;
   int   k = 0, lim_m = 0, phase_m = 0;
   int   cyc = 0, last_evt = 0, cool_until = 0;
   logic p1 = 1'b0, p2 = 1'b0;
   logic done_m = 1'b0;

   qcw_ramp_ctrl #(
      .RAMP_START(START),
      .RAMP_END(END_),
      .RAMP_STEP_CYCLES(STEP),
      .HOLDOFF_CLKS(HOLD)
`ifdef QCW_RAMP_WDOG_EN
      ,
      .WDOG_CLKS(WDOG)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .trigger(trigger),
      .cycle_limit_cfg(cycle_limit_cfg),
      .fault_in(fault_in),
      .fault_clear(fault_clear),
      .pll_cycle_finished(pll_cycle_finished),
      .pll_start(pll_start),
      .pll_halt(pll_halt),
      .pll_phase_shift(pll_phase_shift),
      .pll_cycle_limit(pll_cycle_limit),
      .busy(busy),
      .burst_done(burst_done),
      .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Model: phase from the closed-form rule, holdoff and watchdog as timestamps.
   task automatic model_step();
      logic edge_seen;
      logic wd;
      int   ph;
      cyc++;
      done_m = 1'b0;
      if (!rst_n) begin
         mode = MI; phase_m = 0; lim_m = 0; k = 0; p1 = 1'b0; p2 = 1'b0;
         return;
      end
      edge_seen = p1 && !p2;
      p2 = p1;
      p1 = trigger;
      wd = 1'b0;
`ifdef QCW_RAMP_WDOG_EN
      wd = (mode == MR || mode == MH) && !pll_cycle_finished && (cyc - last_evt == WDOG);
`endif
      if (mode != MF && (fault_in || wd)) begin
         mode = MF;
         phase_m = 0;
      end else begin
         case (mode)
            MI: if (edge_seen && cycle_limit_cfg != 16'd0) begin
                  mode = MA; lim_m = int'(cycle_limit_cfg); k = 0; phase_m = START; last_evt = cyc;
               end
            MA: begin mode = MR; last_evt = cyc; end
            MR, MH: if (pll_cycle_finished) begin
                  k++;
                  last_evt = cyc;
                  if (k == lim_m) begin
                     done_m = 1'b1; mode = MC; cool_until = cyc + HOLD; phase_m = 0;
                  end else begin
                     ph = START + k / STEP;
                     phase_m = (ph > END_) ? END_ : ph;
                     if (phase_m == END_) mode = MH;
                  end
               end
            MC: if (cyc >= cool_until) mode = MI;
            MF: if (fault_clear && !fault_in) begin mode = MC; cool_until = cyc + HOLD; end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("phase", 32'(pll_phase_shift), 32'(phase_m));
      chk("limit", 32'(pll_cycle_limit), 32'(lim_m));
      chk("start", 32'(pll_start), 32'(mode == MA));
      chk("busy", 32'(busy), 32'(mode != MI && mode != MF));
      chk("fault", 32'(fault), 32'(mode == MF));
      chk("halt", 32'(pll_halt), 32'(mode == MF));
      chk("done", 32'(burst_done), 32'(done_m));
   endtask

   task automatic start_burst(input int lim);
      cycle_limit_cfg = 16'(lim);
      trigger = 1'b1;
      tick();
      tick();
      trigger = 1'b0;
   endtask

   task automatic drive_burst(input int lo, input int hi, input bit retrig);
      int wait_n = $urandom_range(lo, hi);
      for (int n = 0; n < 20000 && mode != MI; n++) begin
         pll_cycle_finished = 1'b0;
         if (mode == MR || mode == MH) begin
            if (wait_n == 0) begin
               pll_cycle_finished = 1'b1;
               wait_n = $urandom_range(lo, hi);
            end else begin
               wait_n--;
            end
         end
         if (retrig) begin
            trigger = ($urandom_range(0, 5) == 0);
            if (mode == MR) cycle_limit_cfg = 16'($urandom_range(0, 40));
         end
         tick();
      end
      pll_cycle_finished = 1'b0;
      trigger = 1'b0;
      if (mode != MI) chk("burst_timeout_busy", 32'(busy), 32'd0);
   endtask

   // Return to a quiet IDLE with clean trigger history, finishing any stray burst.
   task automatic idle_wait();
      trigger = 1'b0;
      fault_in = 1'b0;
      cycle_limit_cfg = 16'd5;
      for (int n = 0; n < 6000 && !(mode == MI && !p1 && !p2); n++) begin
         pll_cycle_finished = (mode == MR || mode == MH);
         fault_clear = (mode == MF);
         tick();
      end
      pll_cycle_finished = 1'b0;
      fault_clear = 1'b0;
      if (mode != MI) chk("idle_timeout_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // zero limit is ignored
      start_burst(0);
      repeat (4) tick();

      // nominal burst, pulse every 50 clocks
      start_burst(20);
      drive_burst(49, 49, 1'b0);
      idle_wait();

      // limit reached while still ramping
      start_burst(3);
      drive_burst(0, 3, 1'b0);
      idle_wait();

      // long burst reaching the phase ceiling and HOLD
      start_burst(950);
      drive_burst(0, 1, 1'b0);
      idle_wait();

      // random bursts with retriggers during RAMP and COOLDOWN
      repeat (6) begin
         start_burst($urandom_range(1, 60));
         drive_burst(0, $urandom_range(0, 8), 1'b1);
         idle_wait();
      end

      // fault coincident with the final drive cycle, clear while fault held
      start_burst(20);
      for (int n = 0; n < 400 && k < 19; n++) begin
         pll_cycle_finished = (n % 3 == 2) && (mode == MR || mode == MH);
         tick();
      end
      pll_cycle_finished = 1'b1;
      fault_in = 1'b1;
      tick();
      pll_cycle_finished = 1'b0;
      repeat (3) tick();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      repeat (2) tick();
      fault_in = 1'b0;
      repeat (2) tick();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      idle_wait();

      // drive cycles stall mid-ramp
      start_burst(1000);
      for (int n = 0; n < 10; n++) begin
         pll_cycle_finished = (n % 2 == 1) && (mode == MR);
         tick();
      end
      pll_cycle_finished = 1'b0;
      repeat (STALL) tick();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      drive_burst(0, 1, 1'b0);
      idle_wait();

      // asynchronous reset mid-burst
      start_burst(500);
      for (int n = 0; n < 30; n++) begin
         pll_cycle_finished = (mode == MR) && ($urandom_range(0, 1) == 0);
         tick();
      end
      pll_cycle_finished = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_phase", 32'(pll_phase_shift), 32'd0);
      chk("rst_limit", 32'(pll_cycle_limit), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(pll_start), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_halt", 32'(pll_halt), 32'd0);
      chk("rst_done", 32'(burst_done), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // unconstrained random traffic on every input
      for (int n = 0; n < 3000; n++) begin
         trigger = ($urandom_range(0, 3) == 0);
         cycle_limit_cfg = 16'($urandom_range(0, 6));
         pll_cycle_finished = ($urandom_range(0, 2) == 0);
         fault_in = ($urandom_range(0, 60) == 0);
         fault_clear = ($urandom_range(0, 4) == 0);
         tick();
      end
      idle_wait();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/qcw_ramp_ctrl.md
# qcw_ramp_ctrl

Burst sequencer that drives the QCW phase-locked drive generator. On a trigger it launches one burst, ramps the bridge phase shift from a start value to an end value in steps synchronised to drive cycles, and counts cycles until the burst ends. It then enforces an off-time before the next burst. It latches faults and holds the generator halted until software clears the fault.

## Interface
- `RAMP_START`, 16: phase shift at burst start (8-bit code).
- `RAMP_END`, 240: phase shift ceiling; must be ≥ `RAMP_START`.
- `RAMP_STEP_CYCLES`, 4: drive cycles per +1 phase step (≥1).
- `HOLDOFF_CLKS`, 100000: minimum idle clocks after each burst (32-bit counter).
- `WDOG_CLKS`, 4096: maximum clocks between drive-cycle pulses during a burst (16-bit).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `trigger` in 1: burst request; rising edge, synchronous to `clk`.
- `cycle_limit_cfg` in 16: drive cycles per burst; latched on the accepted trigger edge.
- `fault_in` in 1: external/generator fault, level.
- `fault_clear` in 1: one-clock fault acknowledge.
- `pll_cycle_finished` in 1: one-clock pulse from the generator per drive cycle.
- `pll_start` out 1: one-clock burst start to the generator.
- `pll_halt` out 1: generator halt, level.
- `pll_phase_shift` out 8: phase-shift command.
- `pll_cycle_limit` out 16: latched cycle limit.
- `busy` out 1: high in every state except IDLE and FAULT.
- `burst_done` out 1: one-clock pulse when a burst completes normally.
- `fault` out 1: latched fault flag.

## Operation
- States: IDLE, ARM, RAMP, HOLD, COOLDOWN, FAULT.
- IDLE: a rising edge of `trigger` (registered `trigger`, previous value low) with `cycle_limit_cfg` ≠ 0 and `fault_in` = 0 moves to ARM. On that edge: latch `cycle_limit_cfg` into `pll_cycle_limit`, load `pll_phase_shift` = `RAMP_START`, clear the cycle, step and watchdog counters. Edges with a zero limit are ignored.
- ARM: `pll_start` = 1 for exactly this one clock. Next state is RAMP.
- RAMP: each `pll_cycle_finished` increments `cyc_cnt` and `step_cnt`.
  - When `step_cnt` reaches `RAMP_STEP_CYCLES`, `step_cnt` is cleared and `pll_phase_shift` increments, saturating at `RAMP_END`.
  - On reaching `RAMP_END`, go to HOLD.
- HOLD: phase is frozen; only `cyc_cnt` counts.
- Burst end: in RAMP or HOLD, when the pulse makes `cyc_cnt` == `pll_cycle_limit`, pulse `burst_done`, load the holdoff counter and go to COOLDOWN. End-of-burst takes priority over the phase step and the HOLD transition.
- COOLDOWN: count down `HOLDOFF_CLKS`, then go to IDLE. Triggers are ignored.
- `pll_phase_shift` returns to 0 on entering COOLDOWN or FAULT.
- Fault: `fault_in` = 1 in any state other than FAULT moves to FAULT, with `fault` = 1 and `pll_halt` = 1. Fault has priority over every other transition in the same clock.
- FAULT: `fault_clear` = 1 while `fault_in` = 0 clears `fault` and `pll_halt` and enters COOLDOWN with a full holdoff. A clear while `fault_in` = 1 is ignored.
- Triggers arriving while `busy` or in FAULT are dropped, never queued.

## Timing
- Reset values:
  - state = IDLE
  - `pll_start`, `pll_halt`, `busy`, `burst_done`, `fault` = 0
  - `pll_phase_shift` = 0, `pll_cycle_limit` = 0
  - internal counters = 0, trigger history = 0
- Reset asserted mid-burst forces these values immediately. The generator's own cycle limit ends its burst.
- All outputs are registered.
- Trigger edge sampled at clock edge N: ARM at N+1, `pll_start` high for N+1..N+2, RAMP from N+2.
- A `pll_cycle_finished` pulse at edge M is reflected in counters and phase at M+1.
- `fault_in` at edge M: `pll_halt` and `fault` are high from M+1.
- Phase after k cycles = min(`RAMP_START` + floor(k/`RAMP_STEP_CYCLES`), `RAMP_END`).

## Configuration
- `QCW_RAMP_WDOG_EN` defined:
  - The watchdog counter runs in RAMP and HOLD and clears on each `pll_cycle_finished` and on ARM.
  - Reaching `WDOG_CLKS` enters FAULT exactly as `fault_in` does.
  - The first window is measured from ARM.
- Undefined: no watchdog logic; FAULT is entered only via `fault_in`.

## Test plan
- Normal burst: `cycle_limit_cfg`=20, defaults, pulse every 50 clks → phase 16,16,16,16,17…, `burst_done` after the 20th pulse, phase 0, next trigger accepted exactly `HOLDOFF_CLKS` after.
- Ramp saturation: `RAMP_START`=238, `RAMP_END`=240, step=1, limit=10 → phase 239, 240, then HOLD; `burst_done` after pulse 10.
- Limit hit in RAMP: limit=3, step=1 → COOLDOWN after 3rd pulse; phase never exceeds 18; HOLD is never entered.
- Fault on last-cycle clock: `fault_in` coincident with the 20th pulse → FAULT, no `burst_done`. `fault_clear` while `fault_in`=1 is ignored; after release it gives COOLDOWN.
- Retrigger and zero limit: trigger during RAMP and COOLDOWN is ignored; trigger with limit 0 in IDLE gives no `pll_start`.
- Watchdog (macro on): pulses stop mid-RAMP → `fault`=1 exactly `WDOG_CLKS` clocks after the last pulse. With the macro off, the same stimulus stays in RAMP indefinitely.
